// File: rtl/gpio_hm3_pkg.sv
// Shared GPIO HostMot3 constants: FSM encoding, register map bases and port width.
// Both the read and the write decoders import this package.
package gpio_hm3_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [15:0] PIN_BASE    = 16'h1000;
    localparam logic [15:0] DDR_BASE    = 16'h1100;
    localparam logic [15:0] ODRAIN_BASE = 16'h1300;
    localparam int unsigned REG_STRIDE  = 4;
    localparam int unsigned PORT_WIDTH  = 24;

endpackage

// File: rtl/gpio_sync2.sv
// Parameterized-width two-flop synchronizer with asynchronous active-low reset.
module gpio_sync2 #(
    parameter int unsigned Width = 1
) (
    input  logic             reg_clk,
    input  logic             reset_reg_N,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] meta;

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gpio_readback_decoder.sv
// Host read path of the GPIO slice: returns a pin snapshot or the DDR/open-drain
// register contents with a level handshake on read_reg / busdata_valid.
module gpio_readback_decoder
    import gpio_hm3_pkg::*;
#(
    parameter int unsigned AddrWidth = 16,
    parameter int unsigned BusWidth  = 32,
    parameter int unsigned GPIOWidth = 36,
    parameter int unsigned NumIOReg  = 6
) (
    input  logic                         reg_clk,
    input  logic                         reset_reg_N,
    input  logic                         read_reg,
    input  logic [AddrWidth-3:0]         busaddress,
    input  logic [GPIOWidth-1:0]         io_read_data,
    input  logic [NumIOReg*24-1:0]       ddr_flat,
    input  logic [NumIOReg*24-1:0]       odrain_flat,
    output logic [BusWidth-1:0]          busdata_out,
    output logic                         busdata_valid,
    output logic                         addr_err
);

    localparam int unsigned BankBits = NumIOReg * PORT_WIDTH;

    state_t                 state_q, state_d;
    logic                   rq1, rq2, rise;
    logic [GPIOWidth-1:0]   pins_sync;
    logic [BankBits-1:0]    pins_ext;
    logic [AddrWidth-1:0]   addr_q;
    logic [PORT_WIDTH-1:0]  word;
    logic                   hit;
    logic [BusWidth-1:0]    data_d;
    logic                   valid_d, err_d;

    // rq[0] and rq[1] live in the synchronizer; rq[2] is the edge-detect history flop.
    gpio_sync2 #(.Width(1)) u_rq_sync (
        .reg_clk     (reg_clk),
        .reset_reg_N (reset_reg_N),
        .d           (read_reg),
        .q           (rq1)
    );

    gpio_sync2 #(.Width(GPIOWidth)) u_pin_sync (
        .reg_clk     (reg_clk),
        .reset_reg_N (reset_reg_N),
        .d           (io_read_data),
        .q           (pins_sync)
    );

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) rq2 <= 1'b0;
        else              rq2 <= rq1;
    end

    assign rise     = rq1 & ~rq2;
    assign pins_ext = BankBits'(pins_sync);

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = LOOKUP;
            LOOKUP:  state_d = HOLD;
            HOLD:    if (!rq1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N)                 addr_q <= '0;
        else if (state_q == IDLE && rise) addr_q <= {busaddress, 2'b00};
    end

    // Pin ports beyond the physical pin count fall on the zero padding of pins_ext.
    always_comb begin
        word = '0;
        hit  = 1'b0;
        for (int unsigned k = 0; k < NumIOReg; k++) begin
            if (addr_q == AddrWidth'(PIN_BASE + k * REG_STRIDE)) begin
                hit  = 1'b1;
                word = pins_ext[k*PORT_WIDTH +: PORT_WIDTH];
            end
            if (addr_q == AddrWidth'(DDR_BASE + k * REG_STRIDE)) begin
                hit  = 1'b1;
                word = ddr_flat[k*PORT_WIDTH +: PORT_WIDTH];
            end
            if (addr_q == AddrWidth'(ODRAIN_BASE + k * REG_STRIDE)) begin
                hit  = 1'b1;
                word = odrain_flat[k*PORT_WIDTH +: PORT_WIDTH];
            end
        end
    end

    always_comb begin
        data_d  = busdata_out;
        valid_d = busdata_valid;
        err_d   = 1'b0;
        case (state_q)
            LOOKUP: begin
                data_d  = hit ? BusWidth'(word) : '0;
                valid_d = 1'b1;
                err_d   = ~hit;
            end
            HOLD:    if (!rq1) valid_d = 1'b0;
            default: valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            busdata_out   <= '0;
            busdata_valid <= 1'b0;
            addr_err      <= 1'b0;
        end else begin
            busdata_out   <= data_d;
            busdata_valid <= valid_d;
            addr_err      <= err_d;
        end
    end

endmodule

// File: tb/tb_gpio_readback_decoder.sv
// Scoreboard bench for gpio_readback_decoder: expected words queued at issue time,
// a negedge monitor pops and compares on every rising busdata_valid.
module tb_gpio_readback_decoder;

    logic         reg_clk;
    logic         reset_reg_N;
    logic         read_reg;
    logic [13:0]  busaddress;
    logic [35:0]  io_read_data;
    logic [143:0] ddr_flat;
    logic [143:0] odrain_flat;
    logic [31:0]  busdata_out;
    logic         busdata_valid;
    logic         addr_err;

    int checks;
    int errors;
    logic [32:0] exp_q[$];
    logic        prev_valid;

    gpio_readback_decoder #(
        .AddrWidth (16),
        .BusWidth  (32),
        .GPIOWidth (36),
        .NumIOReg  (6)
    ) dut (
        .reg_clk       (reg_clk),
        .reset_reg_N   (reset_reg_N),
        .read_reg      (read_reg),
        .busaddress    (busaddress),
        .io_read_data  (io_read_data),
        .ddr_flat      (ddr_flat),
        .odrain_flat   (odrain_flat),
        .busdata_out   (busdata_out),
        .busdata_valid (busdata_valid),
        .addr_err      (addr_err)
    );

    initial reg_clk = 1'b0;
    always #5 reg_clk = ~reg_clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: map byte address to {addr_err, data} straight from the register map.
    function automatic logic [32:0] ref_read(input logic [15:0] a);
        int unsigned ai, k;
        logic [143:0] s;
        ai = a;
        if (ai >= 32'h1000 && ai < 32'h1000 + 24) begin
            k = (ai - 32'h1000) / 4;
            if (k == 0) return {1'b0, 8'h00, io_read_data[23:0]};
            if (k == 1) return {1'b0, 20'h0, io_read_data[35:24]};
            return 33'h0;
        end
        if (ai >= 32'h1100 && ai < 32'h1100 + 24) begin
            k = (ai - 32'h1100) / 4;
            s = ddr_flat >> (24 * k);
            return {1'b0, 8'h00, s[23:0]};
        end
        if (ai >= 32'h1300 && ai < 32'h1300 + 24) begin
            k = (ai - 32'h1300) / 4;
            s = odrain_flat >> (24 * k);
            return {1'b0, 8'h00, s[23:0]};
        end
        return {1'b1, 32'h0};
    endfunction

    function automatic logic [143:0] rand144();
        logic [143:0] v;
        v = '0;
        for (int i = 0; i < 5; i++) v = (v << 32) | 144'($urandom);
        return v;
    endfunction

    always @(negedge reg_clk) begin
        logic [32:0] e;
        if (busdata_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response: got %0h expected none", busdata_out);
            end else begin
                e = exp_q.pop_front();
                check("resp_data", 64'(busdata_out), 64'(e[31:0]));
                check("resp_addr_err", 64'(addr_err), 64'(e[32]));
            end
        end
        prev_valid = busdata_valid;
    end

    // Issue a read with read_reg high for h sampled edges; verify timing and held data.
    task automatic run_read(input logic [15:0] a, input int unsigned h, input bit scramble);
        logic [32:0] e;
        int unsigned rise_e, fall_e, exp_fall;
        bit seen_rise, seen_fall;
        e = ref_read(a);
        exp_q.push_back(e);
        busaddress = a[15:2];
        read_reg   = 1'b1;
        exp_fall   = (h + 2 > 4) ? h + 2 : 4;
        seen_rise  = 0;
        seen_fall  = 0;
        rise_e     = 0;
        fall_e     = 0;
        for (int unsigned k = 0; k < h + 30 && !seen_fall; k++) begin
            @(posedge reg_clk);
            #1;
            if (!seen_rise && busdata_valid) begin
                seen_rise = 1;
                rise_e    = k;
            end else if (seen_rise && !busdata_valid) begin
                seen_fall = 1;
                fall_e    = k;
            end
            if (k == 4) check("addr_err_one_cycle", 64'(addr_err), 64'd0);
            if (scramble && k == 2) busaddress = 14'($urandom);
            if (scramble && k == 3) begin
                ddr_flat    = rand144();
                odrain_flat = rand144();
            end
            if (k + 1 == h) read_reg = 1'b0;
        end
        read_reg = 1'b0;
        check("valid_rise_edge", seen_rise ? 64'(rise_e) : 64'hFFFF, 64'd3);
        check("valid_fall_edge", seen_fall ? 64'(fall_e) : 64'hFFFF, 64'(exp_fall));
        check("data_held_after_valid", 64'(busdata_out), 64'(e[31:0]));
        repeat (2) @(posedge reg_clk);
        #1;
    endtask

    initial begin
        logic [15:0] a;
        checks       = 0;
        errors       = 0;
        prev_valid   = 1'b0;
        reset_reg_N  = 1'b0;
        read_reg     = 1'b0;
        busaddress   = '0;
        io_read_data = '0;
        ddr_flat     = '0;
        odrain_flat  = '0;
        repeat (3) @(posedge reg_clk);
        #1;
        check("reset_data", 64'(busdata_out), 64'd0);
        check("reset_valid", 64'(busdata_valid), 64'd0);
        check("reset_addr_err", 64'(addr_err), 64'd0);
        reset_reg_N = 1'b1;
        @(posedge reg_clk);
        #1;

        ddr_flat[23:0] = 24'hA5A5A5;
        run_read(16'h1100, 4, 0);

        io_read_data = {12'hFFF, 24'h123456};
        run_read(16'h1004, 3, 0);
        run_read(16'h1000, 2, 0);

        odrain_flat[143:120] = 24'h00BEEF;
        run_read(16'h1314, 3, 0);
        run_read(16'h1200, 3, 0);

        ddr_flat[47:24] = 24'h5A1234;
        run_read(16'h1104, 1, 0);

        run_read(16'h1108, 20, 1);

        // Reset in HOLD, released with read_reg still high.
        ddr_flat = rand144();
        exp_q.push_back(ref_read(16'h110C));
        busaddress = 14'h110C >> 2;
        read_reg   = 1'b1;
        repeat (5) @(posedge reg_clk);
        #1;
        check("pre_reset_valid", 64'(busdata_valid), 64'd1);
        reset_reg_N = 1'b0;
        #1;
        check("midreset_data", 64'(busdata_out), 64'd0);
        check("midreset_valid", 64'(busdata_valid), 64'd0);
        check("midreset_addr_err", 64'(addr_err), 64'd0);
        @(posedge reg_clk);
        #1;
        reset_reg_N = 1'b1;
        run_read(16'h1304, 4, 0);

        for (int i = 0; i < 40; i++) begin
            io_read_data = {4'($urandom), 32'($urandom)};
            ddr_flat     = rand144();
            odrain_flat  = rand144();
            case ($urandom_range(0, 3))
                0: a = 16'h1000 + 16'(4 * $urandom_range(0, 5));
                1: a = 16'h1100 + 16'(4 * $urandom_range(0, 5));
                2: a = 16'h1300 + 16'(4 * $urandom_range(0, 5));
                default: a = {16'($urandom) & 16'hFFFC};
            endcase
            run_read(a, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge reg_clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gpio_readback_decoder.md
# gpio_readback_decoder

Read-side companion to the GPIO DDR/open-drain write decoder. It services host bus reads of the GPIO block and returns one 32-bit word with a level handshake. The word is either a synchronized snapshot of the GPIO pin inputs or the current DDR or open-drain register contents. It sits beside the write decoder in the HostMot3 GPIO slice and shares its address map and register clock.

## Interface
- AddrWidth, 16, full byte-address width; the bus delivers the word address [AddrWidth-3:0]
- BusWidth, 32, read data width
- GPIOWidth, 36, number of GPIO pins
- NumIOReg, 6, number of 24-bit port registers per bank
- reg_clk  in  1  register clock; all logic on its rising edge
- reset_reg_N  in  1  asynchronous, active-low reset
- read_reg  in  1  read request level; may come from another domain
- busaddress  in  AddrWidth-2  word address; must be stable while read_reg is high
- io_read_data  in  GPIOWidth  raw pin input values from the bidirectional pad block
- ddr_flat  in  NumIOReg*24  DDR registers; port k occupies [24k+23:24k]
- odrain_flat  in  NumIOReg*24  open-drain registers, same packing as ddr_flat
- busdata_out  out  BusWidth  read data; reset value 0
- busdata_valid  out  1  read data valid; reset value 0
- addr_err  out  1  one-cycle pulse when the read address is unmapped; reset value 0

## Operation
- Address map (byte address = {busaddress, 2'b00}):
  - 0x1000 + 4k, k = 0..NumIOReg-1: pin input port k
  - 0x1100 + 4k: DDR register k
  - 0x1300 + 4k: open-drain register k
- All returned data is zero-extended to 32 bits.
- Pin port packing:
  - port 0 = pins [23:0]
  - port 1 = pins [35:24] in bits [11:0]
  - ports 2..5 read 0
- Unmapped address: return 0 and pulse addr_err in the LOOKUP cycle.
- read_reg passes through a 3-flop chain rq[2:0]. A rise is detected when rq[1] & ~rq[2].
- io_read_data passes through a 2-flop synchronizer. The snapshot is taken from the second stage.
- State machine, encoding in the package:
  - IDLE: on a detected rise, latch the byte address, then go to LOOKUP.
  - LOOKUP: decode the latched address, register busdata_out, set busdata_valid=1, then go to HOLD.
  - HOLD: busdata_valid stays 1 and busdata_out is frozen. When rq[1]==0, clear busdata_valid and go to IDLE.
- busdata_out keeps its last value after valid drops. It is never tristated.

## Timing
- read_reg is first sampled high at edge 0:
  - edge 2: address latched
  - edge 3: busdata_out and busdata_valid=1
- Pin snapshot: a pin value presented at edge e is visible if e ≤ edge 1, because of the 2-flop latency.
- read_reg falls, first sampled low at edge f: busdata_valid drops at edge f+2.
- Boundary conditions:
  - read_reg pulse shorter than the latency: still completes. Valid lasts 1 cycle if rq[1] is already low on entry to HOLD.
  - read_reg held high continuously: exactly one response. A new read needs a low phase.
  - Rise arriving while in HOLD: ignored until the return to IDLE. It is a new rise only if rq still shows the 0→1 transition then.
  - ddr_flat or odrain_flat changing during HOLD: no effect; the data is already registered.
  - Reset asserted mid-transaction: all outputs and registers go to 0 immediately and the state becomes IDLE. After release, a read_reg already high is treated as a new rise.

## Structure
- Package gpio_hm3_pkg:
  - state enum (IDLE, LOOKUP, HOLD)
  - base addresses 0x1000, 0x1100, 0x1300, and stride 4
  - port width 24
  - the write decoder is to import the same constants
- Sub-module gpio_sync2: parameterized-width 2-flop synchronizer with async active-low reset. It is used for both io_read_data and the read_reg chain.

## Test plan
- Reset, then read 0x1100 with ddr_flat[23:0]=0xA5A5A5 -> busdata_out=0x00A5A5A5 and valid at edge 3; valid drops 2 edges after read_reg falls.
- Drive pins [35:24]=0xFFF and [23:0]=0x123456; read 0x1004 -> 0x00000FFF; read 0x1000 -> 0x00123456.
- Read 0x1314 with odrain_flat[143:120]=0x00BEEF -> 0x0000BEEF; read 0x1200 -> 0x00000000 with addr_err high for exactly 1 cycle.
- 1-cycle read_reg pulse at 0x1104 -> one response; busdata_valid high for 1 cycle; busdata_out keeps the value afterwards.
- read_reg held high for 20 cycles while busaddress changes after edge 2 -> single response with the first address's data.
- Assert reset_reg_N low in HOLD -> busdata_out=0, valid=0, addr_err=0 immediately; release with read_reg high -> a fresh response 3 edges later.
